// File: rtl/my_multiplier_core.sv
// ---------------------------------------------------------------------------
// my_multiplier_core
//
// Sequential unsigned shift-add multiplier. Operands arrive through a
// valid/ready handshake. The full 2*WIDTH-bit product is built over exactly
// WIDTH cycles and is returned through a second valid/ready handshake. A
// wrapping counter records how many products have been delivered.
//
// Parameters
//   WIDTH     operand width (4..32); the product is 2*WIDTH bits
//   CNT_W     width of the completed-operation counter
//
// Ports
//   ACLK      clock, all logic on the rising edge
//   ARESET    synchronous active-high reset
//   in_valid  operands valid             in_ready  core can accept operands
//   in_a      multiplicand               in_b      multiplier
//   abort     cancel an operation that is still in BUSY
//   out_valid product valid              out_ready downstream accepts product
//   out_prod  registered product A*B
//   busy      registered, high while in BUSY or DONE
//   op_count  number of delivered products, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module my_multiplier_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int                STEP_W    = $clog2(WIDTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [2*WIDTH:0]     p_reg;        // partial product, carry bit on top
    logic [WIDTH-1:0]     a_reg;
    logic [STEP_W-1:0]    step_reg;
    logic [2*WIDTH-1:0]   out_prod_reg;
    logic                 busy_reg;
    logic [CNT_W-1:0]     op_count_reg;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     p_shift;
    logic                 last_step;

    // Upper half plus multiplicand, carry kept in bit WIDTH.
    assign sum = {1'b0, p_reg[2*WIDTH-1:WIDTH]} + {1'b0, a_reg};

    // Conditional add followed by a one-bit right shift with zero fill.
    // The LSB of the pre-shift value is dropped by the shift, so it is only
    // used as the add select.
    assign p_shift = p_reg[0] ? {1'b0, sum, p_reg[WIDTH-1:1]}
                              : {1'b0, p_reg[2*WIDTH:1]};

    assign last_step = (step_reg == LAST_STEP);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // abort wins even on the final step: no result is produced
                if (abort) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_reg    <= IDLE;
            p_reg        <= '0;
            a_reg        <= '0;
            step_reg     <= '0;
            out_prod_reg <= '0;
            busy_reg     <= 1'b0;
            op_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != IDLE);
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        p_reg    <= {{(WIDTH + 1){1'b0}}, in_b};
                        step_reg <= '0;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        p_reg    <= '0;
                        step_reg <= '0;
                    end else begin
                        p_reg    <= p_shift;
                        step_reg <= step_reg + STEP_W'(1);
                        // out_prod only changes on entry to DONE
                        if (last_step) begin
                            out_prod_reg <= p_shift[2*WIDTH-1:0];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        op_count_reg <= op_count_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_prod  = out_prod_reg;
    assign busy      = busy_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_my_multiplier_core.sv
// ---------------------------------------------------------------------------
// Directed bench for my_multiplier_core (WIDTH=32, CNT_W=4 so the counter
// wrap is reachable). A vector table covers the arithmetic; hand-written
// sequences cover backpressure, ignored inputs, abort, reset and wrap.
// ---------------------------------------------------------------------------
module tb_my_multiplier_core;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic                ACLK = 1'b0;
    logic                ARESET;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                abort;
    logic                out_valid;
    logic                out_ready;
    logic [2*WIDTH-1:0]  out_prod;
    logic                busy;
    logic [CNT_W-1:0]    op_count;

    my_multiplier_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [2*WIDTH-1:0] prod;
    } vec_t;

    vec_t vecs [10];

    int n_cmp = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] exp_count = '0;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Accept one operand pair (in_valid for one cycle). Returns the number of
    // cycles from the accept edge until out_valid is seen.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input string name, output int lat);
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            tick();
            waitc++;
        end
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Full operation with out_ready held high.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2*WIDTH-1:0] prod, input string name);
        int lat;
        out_ready = 1'b1;
        start_op(a, b, name, lat);
        check({name, "_latency"}, 64'(lat), 64'd32);
        check({name, "_prod"}, out_prod, prod);
        tick();
        exp_count = exp_count + 1'b1;
        check({name, "_op_count"}, 64'(op_count), 64'(exp_count));
        check({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
        $display("op %s: a=0x%08h b=0x%08h prod=0x%016h lat=%0d count=%0d",
                 name, a, b, out_prod, lat, op_count);
    endtask

    initial begin
        int lat;
        int hits;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[3] = '{32'd0,          32'h1234_5678,  64'h0};
        vecs[4] = '{32'hDEAD_BEEF,  32'd0,          64'h0};
        vecs[5] = '{32'h1234_5678,  32'd1,          64'h0000_0000_1234_5678};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
        vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
        vecs[8] = '{32'd1000,       32'd1000,       64'h0000_0000_000F_4240};
        vecs[9] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001};

        ARESET = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        abort = 1'b0; out_ready = 1'b1;
        tick(); tick();
        ARESET = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_prod",  out_prod,       64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_op_count",  64'(op_count),  64'd0);

        // ---- table-driven products ----
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
        end

        // ---- backpressure: 7x6 held for 10 cycles ----
        out_ready = 1'b0;
        start_op(32'd7, 32'd6, "bp", lat);
        check("bp_latency", 64'(lat), 64'd32);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_prod",  out_prod,       64'h2A);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",   64'(in_ready),  64'd0);
            check("bp_op_count",   64'(op_count),  64'(exp_count));
        end
        out_ready = 1'b1;
        tick();
        exp_count = exp_count + 1'b1;
        check("bp_op_count_after", 64'(op_count), 64'(exp_count));
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        $display("op bp: 7x6 prod=0x%0h count=%0d", out_prod, op_count);

        // ---- in_valid during BUSY must be ignored ----
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 32'd2; in_b = 32'd2;
        tick();
        in_a = 32'd9; in_b = 32'd9;   // in_valid stays high
        lat = 0;
        while (!out_valid && lat < 100) begin
            check("ib_in_ready_low", 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
        check("ib_latency", 64'(lat), 64'd32);
        check("ib_prod", out_prod, 64'd4);
        check("ib_in_ready_done", 64'(in_ready), 64'd0);
        in_valid = 1'b0; in_a = '0; in_b = '0;
        tick();
        exp_count = exp_count + 1'b1;
        check("ib_op_count", 64'(op_count), 64'(exp_count));
        $display("op ib: 2x2 with 9x9 pending, prod=0x%0h", out_prod);

        // ---- abort at step 10 of 5x5 ----
        in_valid = 1'b1; in_a = 32'd5; in_b = 32'd5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_in_ready", 64'(in_ready), 64'd1);
        check("ab_busy",     64'(busy),     64'd0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) hits++;
            tick();
        end
        check("ab_no_out_valid", 64'(hits), 64'd0);
        check("ab_op_count", 64'(op_count), 64'(exp_count));
        $display("op abort: 5x5 aborted at step 10, count=%0d", op_count);
        do_op(32'd4, 32'd4, 64'd16, "post_abort");

        // ---- abort on the final BUSY step ----
        in_valid = 1'b1; in_a = 32'd11; in_b = 32'd13;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 31; i++) tick();
        check("abl_still_busy", 64'(out_valid), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abl_out_valid", 64'(out_valid), 64'd0);
        check("abl_in_ready",  64'(in_ready),  64'd1);
        check("abl_prod_held", out_prod,       64'd16);
        check("abl_op_count",  64'(op_count),  64'(exp_count));
        $display("op abort_last: 11x13 aborted on final step, prod kept=0x%0h", out_prod);

        // ---- reset at step 20 ----
        in_valid = 1'b1; in_a = 32'd100; in_b = 32'd100;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        exp_count = '0;
        check("mr_in_ready",  64'(in_ready),  64'd1);
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_prod",  out_prod,       64'd0);
        check("mr_busy",      64'(busy),      64'd0);
        check("mr_op_count",  64'(op_count),  64'd0);
        $display("op reset: mid-BUSY reset, count=%0d", op_count);

        // ---- counter wrap: 16 ops of 1x1 ----
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("wrap_before", 64'(op_count), 64'd15);
            do_op(32'd1, 32'd1, 64'd1, $sformatf("wrap%0d", i));
        end
        check("wrap_after", 64'(op_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
